// File: rtl/alu_rf_pipe_if.sv
// Command/result handshake bundle for the alu_rf_pipe execution unit.
// The master issues commands and consumes results; the slave is the unit.
interface alu_rf_pipe_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic          cmd_imm_sel;
  logic [DW-1:0] cmd_imm;
  logic [AW-1:0] cmd_rd;
  logic          cmd_we;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_zero;
  logic [AW-1:0] res_rd;

  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_imm_sel, cmd_imm, cmd_rd, cmd_we,
    input  cmd_ready,
    input  res_valid, res_data, res_zero, res_rd,
    output res_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_imm_sel, cmd_imm, cmd_rd, cmd_we,
    output cmd_ready,
    output res_valid, res_data, res_zero, res_rd,
    input  res_ready
  );
endinterface

// File: rtl/alu_rf_pipe.sv
// Register file + 8-op ALU, two-stage (EX, WB) pipeline with full operand
// forwarding and result backpressure; debug port reads the architectural RF.
module alu_rf_pipe #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rstn,
  alu_rf_pipe_if.slave  bus,
  input  logic          wr_protect,
  output logic          busy,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);
  localparam int unsigned DEPTH = 1 << AW;
  localparam int          SHW   = $clog2(DW);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SLT = 3'd7
  } op_e;

  logic [DW-1:0] rf [DEPTH];

  logic          ex_valid;
  op_e           ex_op;
  logic [DW-1:0] ex_a, ex_b;
  logic [AW-1:0] ex_rd;
  logic          ex_we;

  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_rd;
  logic          wb_we;

  logic [DW-1:0] alu_out;
  logic [DW-1:0] op_a, op_b;
  logic          accept, retire, ex_adv, eff_we;

  assign retire        = wb_valid & bus.res_ready;
  assign ex_adv        = ex_valid & (~wb_valid | retire);
  assign bus.cmd_ready = ~ex_valid | ex_adv;
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign eff_we        = bus.cmd_we & ~wr_protect &
                         ~((ZERO_REG != 0) && (bus.cmd_rd == '0));

  // Youngest effective producer wins; non-effective writes are invisible.
  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] r);
    if ((ZERO_REG != 0) && (r == '0))           return '0;
    else if (ex_valid && ex_we && (ex_rd == r)) return alu_out;
    else if (wb_valid && wb_we && (wb_rd == r)) return wb_data;
    else                                        return rf[r];
  endfunction

  always_comb begin
    op_a = fwd(bus.cmd_rs1);
    op_b = bus.cmd_imm_sel ? bus.cmd_imm : fwd(bus.cmd_rs2);
  end

  always_comb begin
    alu_out = '0;
    case (ex_op)
      OP_ADD: alu_out = ex_a + ex_b;
      OP_SUB: alu_out = ex_a - ex_b;
      OP_AND: alu_out = ex_a & ex_b;
      OP_OR:  alu_out = ex_a | ex_b;
      OP_XOR: alu_out = ex_a ^ ex_b;
      OP_SLL: alu_out = ex_a << ex_b[SHW-1:0];
      OP_SRL: alu_out = ex_a >> ex_b[SHW-1:0];
      OP_SLT: alu_out[0] = $signed(ex_a) < $signed(ex_b);
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid <= 1'b0;
      ex_op    <= OP_ADD;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_rd    <= '0;
      ex_we    <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_op    <= op_e'(bus.cmd_op);
      ex_a     <= op_a;
      ex_b     <= op_b;
      ex_rd    <= bus.cmd_rd;
      ex_we    <= eff_we;
    end else if (ex_adv) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      wb_we    <= 1'b0;
    end else if (ex_adv) begin
      wb_valid <= 1'b1;
      wb_data  <= alu_out;
      wb_rd    <= ex_rd;
      wb_we    <= ex_we;
    end else if (retire) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (retire && wb_we) begin
      rf[wb_rd] <= wb_data;
    end
  end

  assign bus.res_valid = wb_valid;
  assign bus.res_data  = wb_data;
  assign bus.res_rd    = wb_rd;
  assign bus.res_zero  = wb_valid && (wb_data == '0);
  assign busy          = ex_valid | wb_valid;
  assign dbg_data      = rf[dbg_addr];
endmodule

// File: tb/tb_alu_rf_pipe.sv
// Self-checking bench for alu_rf_pipe: vector table plus hand-written
// backpressure, protection and mid-pipeline reset sequences, queue scoreboard.
module tb_alu_rf_pipe;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr_protect = 1'b0;
  logic          busy;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;

  alu_rf_pipe_if #(.DW(DW), .AW(AW)) bus ();

  alu_rf_pipe #(.DW(DW), .AW(AW), .ZERO_REG(1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus.slave),
    .wr_protect (wr_protect),
    .busy       (busy),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] rd;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t q[$];

  // Scoreboard monitor: every presented result must match the queue head.
  bit mon_en = 1'b0;
  bit held = 1'b0;
  int first_cyc = 0;
  always @(negedge clk) begin
    if (mon_en && bus.res_valid) begin
      if (q.size() == 0) begin
        chk("res_unexpected", 32'h1, 32'h0);
      end else begin
        if (!held) first_cyc = cyc;
        chk("res_data", bus.res_data, q[0].data);
        chk("res_rd", {{(DW-AW){1'b0}}, bus.res_rd}, {{(DW-AW){1'b0}}, q[0].rd});
        chk("res_zero", {{(DW-1){1'b0}}, bus.res_zero}, {{(DW-1){1'b0}}, (q[0].data == '0)});
        if (bus.res_ready) begin
          if (q[0].lat) chk("latency", 32'(first_cyc - q[0].cyc), 32'd2);
          void'(q.pop_front());
        end
      end
    end
    held = mon_en && bus.res_valid && !bus.res_ready;
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic isel, input logic [DW-1:0] imm, input logic [AW-1:0] rd,
                       input logic we, input logic prot, input logic [DW-1:0] exp,
                       input bit lat, input bit push, input bit want_ready);
    bit ok;
    bit first;
    exp_t e;
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_rs1     = rs1;
    bus.cmd_rs2     = rs2;
    bus.cmd_imm_sel = isel;
    bus.cmd_imm     = imm;
    bus.cmd_rd      = rd;
    bus.cmd_we      = we;
    wr_protect      = prot;
    ok = 1'b0;
    first = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (first && want_ready) chk("cmd_ready_now", {31'd0, bus.cmd_ready}, 32'd1);
      first = 1'b0;
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk("accept_timeout", 32'h0, 32'h1);
    end else begin
      if (push) begin
        e.data = exp; e.rd = rd; e.cyc = cyc; e.lat = lat;
        q.push_back(e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    bit ok;
    bus.cmd_valid = 1'b0;
    wr_protect = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'h0, 32'h1);
  endtask

  task automatic dbg_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("dbg_r%0d", a), dbg_data, exp);
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          isel;
    logic [DW-1:0] imm;
    logic [AW-1:0] rd;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // op: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SLT
    tbl[0]  = '{3'd3, 5'd0,  5'd0,  1'b1, 32'h0000_0005, 5'd1,  32'h0000_0005};
    tbl[1]  = '{3'd3, 5'd0,  5'd0,  1'b1, 32'h0000_0003, 5'd2,  32'h0000_0003};
    tbl[2]  = '{3'd0, 5'd1,  5'd2,  1'b0, 32'h0,         5'd3,  32'h0000_0008};
    tbl[3]  = '{3'd1, 5'd3,  5'd1,  1'b0, 32'h0,         5'd4,  32'h0000_0003};
    tbl[4]  = '{3'd2, 5'd3,  5'd4,  1'b0, 32'h0,         5'd5,  32'h0000_0000};
    tbl[5]  = '{3'd3, 5'd0,  5'd0,  1'b1, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF};
    tbl[6]  = '{3'd0, 5'd7,  5'd0,  1'b1, 32'h0000_0001, 5'd8,  32'h0000_0000};
    tbl[7]  = '{3'd3, 5'd0,  5'd0,  1'b1, 32'h0000_0001, 5'd9,  32'h0000_0001};
    tbl[8]  = '{3'd5, 5'd9,  5'd0,  1'b1, 32'd33,        5'd10, 32'h0000_0002};
    tbl[9]  = '{3'd3, 5'd0,  5'd0,  1'b1, 32'h8000_0000, 5'd11, 32'h8000_0000};
    tbl[10] = '{3'd7, 5'd11, 5'd0,  1'b1, 32'h0000_0001, 5'd12, 32'h0000_0001};
    tbl[11] = '{3'd6, 5'd11, 5'd0,  1'b1, 32'd31,        5'd13, 32'h0000_0001};
    tbl[12] = '{3'd4, 5'd7,  5'd9,  1'b0, 32'h0,         5'd14, 32'hFFFF_FFFE};
    tbl[13] = '{3'd7, 5'd9,  5'd11, 1'b0, 32'h0,         5'd15, 32'h0000_0000};

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
    bus.cmd_imm_sel = 1'b0; bus.cmd_imm = '0; bus.cmd_rd = '0; bus.cmd_we = 1'b0;
    bus.res_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_res_zero", {31'd0, bus.res_zero}, 32'd0);
    for (int a = 0; a < 32; a++) dbg_chk(AW'(a), 32'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Back-to-back vectors with hazards on nearly every operand.
    for (int i = 0; i < 14; i++)
      issue(tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].isel, tbl[i].imm, tbl[i].rd,
            1'b1, 1'b0, tbl[i].exp, 1'b1, 1'b1, 1'b1);
    drain();
    for (int i = 0; i < 14; i++) dbg_chk(tbl[i].rd, tbl[i].exp);
    @(posedge clk); #1;

    // Backpressure: third command must wait until results drain.
    bus.res_ready = 1'b0;
    issue(3'd3, 5'd0, 5'd0, 1'b1, 32'h11, 5'd16, 1'b1, 1'b0, 32'h11, 1'b0, 1'b1, 1'b1);
    issue(3'd3, 5'd0, 5'd0, 1'b1, 32'h22, 5'd17, 1'b1, 1'b0, 32'h22, 1'b0, 1'b1, 1'b1);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_rs1 = 5'd16; bus.cmd_rs2 = 5'd17;
    bus.cmd_imm_sel = 1'b0; bus.cmd_rd = 5'd18; bus.cmd_we = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    issue(3'd0, 5'd16, 5'd17, 1'b0, 32'h0, 5'd18, 1'b1, 1'b0, 32'h33, 1'b0, 1'b1, 1'b1);
    drain();
    dbg_chk(5'd16, 32'h11);
    dbg_chk(5'd17, 32'h22);
    dbg_chk(5'd18, 32'h33);
    @(posedge clk); #1;

    // Write protection and register 0: results still flow, no RF update.
    issue(3'd0, 5'd1, 5'd0, 1'b1, 32'd1,  5'd6,  1'b1, 1'b0, 32'd6,  1'b1, 1'b1, 1'b1);
    issue(3'd0, 5'd1, 5'd0, 1'b1, 32'd10, 5'd6,  1'b1, 1'b1, 32'd15, 1'b1, 1'b1, 1'b1);
    issue(3'd3, 5'd6, 5'd0, 1'b1, 32'd0,  5'd19, 1'b1, 1'b0, 32'd6,  1'b1, 1'b1, 1'b1);
    issue(3'd3, 5'd0, 5'd0, 1'b1, 32'd7,  5'd0,  1'b1, 1'b0, 32'd7,  1'b1, 1'b1, 1'b1);
    issue(3'd3, 5'd0, 5'd0, 1'b1, 32'd0,  5'd20, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1);
    drain();
    dbg_chk(5'd6, 32'd6);
    dbg_chk(5'd0, 32'd0);
    dbg_chk(5'd19, 32'd6);
    dbg_chk(5'd20, 32'd0);
    @(posedge clk); #1;

    // Reset with EX and WB both occupied: nothing may reach the RF.
    mon_en = 1'b0;
    bus.res_ready = 1'b0;
    issue(3'd3, 5'd0, 5'd0, 1'b1, 32'h55, 5'd21, 1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 1'b1);
    issue(3'd3, 5'd0, 5'd0, 1'b1, 32'h66, 5'd22, 1'b1, 1'b0, 32'h66, 1'b0, 1'b0, 1'b1);
    bus.cmd_valid = 1'b0;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("mid_rst_res_data", bus.res_data, 32'd0);
    bus.res_ready = 1'b1;
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    dbg_chk(5'd21, 32'd0);
    dbg_chk(5'd22, 32'd0);
    dbg_chk(5'd1, 32'd0);
    dbg_chk(5'd6, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
